// File: rtl/tis_exec_core.sv
// -----------------------------------------------------------------------------
// tis_exec_core
//
// Execution core of one TIS node. It holds the ACC/BAK datapath, a saturating
// ALU, the program counter with jump logic, and blocking neighbour ports.
// The instruction store lives outside the core and is read asynchronously by
// the program counter (Addr_instr -> instr).
//
// Instruction word (IW = 12 + W bits):
//   op  = instr[IW-1 -: 4], src = instr[IW-5 -: 4], dst = instr[IW-9 -: 4],
//   imm = instr[W-1:0]
// Operand codes: 0 IMM (source only), 1 ACC, 2 NIL, 3+i neighbour port i.
// Port codes at or above 3+NPORT behave as NIL and never stall.
//
// Optional feature, macro TIS_ANY_LAST_EN:
//   15 = ANY  (read: lowest-index valid port wins; write: offered on all ports,
//              lowest-index ready completes)
//   14 = LAST (port most recently used by ANY; NIL after reset)
// With the macro undefined, codes 14 and 15 behave as NIL.
//
// Handshake rule (both directions): a word moves on a rising edge where
// valid and ready are both high on the same port. The core raises in_ready
// only in RD_WAIT and out_valid only in WR_WAIT; both are forced low while
// hlt is high, so nothing moves during a freeze.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   hlt               freeze: no state change while high
//   instr             instruction at Addr_instr
//   Addr_instr        program counter
//   in_data/valid     neighbour read data, slice i = [i*W +: W]
//   in_ready          core accepting on port i
//   out_data          write data, same value on every slice
//   out_valid         core offering data on port i
//   out_ready         neighbour accepts on port i
//   ACCond            current ACC
//   busy              high in RD_WAIT or WR_WAIT
//   dbg_state         FSM state (0 EXEC, 1 RD_WAIT, 2 WR_WAIT, 3 HALTED)
// -----------------------------------------------------------------------------
module tis_exec_core #(
  parameter int W        = 8,
  parameter int NPORT    = 4,
  parameter int AW       = 8,
  parameter int PROG_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hlt,
  input  logic [12+W-1:0]      instr,
  output logic [AW-1:0]        Addr_instr,
  input  logic [NPORT*W-1:0]   in_data,
  input  logic [NPORT-1:0]     in_valid,
  output logic [NPORT-1:0]     in_ready,
  output logic [NPORT*W-1:0]   out_data,
  output logic [NPORT-1:0]     out_valid,
  input  logic [NPORT-1:0]     out_ready,
  output logic [W-1:0]         ACCond,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int IW = 12 + W;

  typedef enum logic [1:0] {
    S_EXEC    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_SWP = 4'd2;
  localparam logic [3:0] OP_SAV = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JEZ = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9;
  localparam logic [3:0] OP_JGZ = 4'd10;
  localparam logic [3:0] OP_JLZ = 4'd11;
  localparam logic [3:0] OP_JRO = 4'd12;
  localparam logic [3:0] OP_HCF = 4'd13;

  localparam logic [3:0] C_IMM  = 4'd0;
  localparam logic [3:0] C_ACC  = 4'd1;
`ifdef TIS_ANY_LAST_EN
  localparam logic [3:0] C_NIL  = 4'd2;
  localparam logic [3:0] C_LAST = 4'd14;
  localparam logic [3:0] C_ANY  = 4'd15;
`endif

  // Symmetric saturation limits: -128 is never produced by the ALU.
  localparam logic signed [W:0]   SMAX      = (W+1)'(2**(W-1) - 1);
  localparam logic signed [W:0]   SMIN      = -SMAX;
  localparam logic [AW-1:0]       PC_LAST   = AW'(PROG_LEN - 1);
  localparam logic signed [W+1:0] PC_LAST_S = (W+2)'(PROG_LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    bak_q, bak_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [3:0]      rd_code_q, rd_code_d;   // port code being read in RD_WAIT
  logic [3:0]      wr_code_q, wr_code_d;   // port code being written in WR_WAIT
  logic [W-1:0]    odata_q, odata_d;       // word offered in WR_WAIT
`ifdef TIS_ANY_LAST_EN
  logic [3:0]      last_q, last_d;
  logic [3:0]      rd_hit, wr_hit;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [3:0]   op, src, dst;
  logic [W-1:0] imm;
  logic [3:0]   src_eff, dst_eff;
  logic         src_chan, dst_chan;
  logic [W-1:0] src_val;
  logic [AW-1:0] jmp_tgt, pc_inc;

  assign op  = instr[IW-1 -: 4];
  assign src = instr[IW-5 -: 4];
  assign dst = instr[IW-9 -: 4];
  assign imm = instr[W-1:0];

  function automatic logic is_port(input logic [3:0] c);
    return (c >= 4'd3) && (int'(c) < 3 + NPORT);
  endfunction

  function automatic logic is_chan(input logic [3:0] c);
`ifdef TIS_ANY_LAST_EN
    return is_port(c) || (c == C_ANY);
`else
    return is_port(c);
`endif
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [W:0] v);
    if (v > SMAX)      return SMAX[W-1:0];
    else if (v < SMIN) return SMIN[W-1:0];
    else               return v[W-1:0];
  endfunction

  // LAST is an alias: resolve it to the remembered port code before decode.
  always_comb begin
    src_eff = src;
    dst_eff = dst;
`ifdef TIS_ANY_LAST_EN
    if (src == C_LAST) src_eff = last_q;
    if (dst == C_LAST) dst_eff = last_q;
`endif
  end

  // Only MOV/ADD/SUB/JRO read their source; other opcodes never stall on it.
  assign src_chan = ((op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_JRO)) && is_chan(src_eff);
  assign dst_chan = (op == OP_MOV) && is_chan(dst_eff);

  always_comb begin
    src_val = '0;
    if (src_eff == C_IMM)      src_val = imm;
    else if (src_eff == C_ACC) src_val = acc_q;
  end

  assign jmp_tgt = AW'(32'(imm[AW-1:0]) % 32'(PROG_LEN));
  assign pc_inc  = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [NPORT-1:0] rd_ready;
  logic [W-1:0]     rd_val;
  logic             rd_fire;

  always_comb begin
    rd_ready = '0;
    rd_val   = '0;
`ifdef TIS_ANY_LAST_EN
    rd_hit   = C_NIL;
`endif
    if ((state_q == S_RD_WAIT) && !hlt) begin
`ifdef TIS_ANY_LAST_EN
      // ANY: ready on every port until someone offers, then only the winner.
      if (rd_code_q == C_ANY) begin
        rd_ready = '1;
        for (int i = NPORT - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            rd_ready    = '0;
            rd_ready[i] = 1'b1;
          end
        end
      end else
`endif
      for (int i = 0; i < NPORT; i++) begin
        if (rd_code_q == 4'(i + 3)) rd_ready[i] = 1'b1;
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      if (rd_ready[i] && in_valid[i]) begin
        rd_val = in_data[i*W +: W];
`ifdef TIS_ANY_LAST_EN
        rd_hit = 4'(i + 3);
`endif
      end
    end
  end

  assign rd_fire  = |(rd_ready & in_valid);
  assign in_ready = rd_ready;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic wr_fire;

  always_comb begin
    out_valid = '0;
`ifdef TIS_ANY_LAST_EN
    wr_hit    = C_NIL;
`endif
    if ((state_q == S_WR_WAIT) && !hlt) begin
`ifdef TIS_ANY_LAST_EN
      if (wr_code_q == C_ANY) out_valid = '1;
      else
`endif
      for (int i = 0; i < NPORT; i++) begin
        if (wr_code_q == 4'(i + 3)) out_valid[i] = 1'b1;
      end
    end
`ifdef TIS_ANY_LAST_EN
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (out_valid[i] && out_ready[i]) wr_hit = 4'(i + 3);
    end
`endif
  end

  assign wr_fire  = |(out_valid & out_ready);
  assign out_data = {NPORT{odata_q}};

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  logic [W-1:0]      opv;
  logic              do_op;
  logic signed [W+1:0] jro_t;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bak_d     = bak_q;
    pc_d      = pc_q;
    rd_code_d = rd_code_q;
    wr_code_d = wr_code_q;
    odata_d   = odata_q;
`ifdef TIS_ANY_LAST_EN
    last_d    = last_q;
`endif
    jro_t     = '0;
    do_op     = 1'b0;
    // In RD_WAIT the instruction is still at PC, so the operand comes from
    // the handshaking port and the rest of the op completes normally.
    opv       = (state_q == S_RD_WAIT) ? rd_val : src_val;

    case (state_q)
      S_EXEC: begin
        if (src_chan) begin
          state_d   = S_RD_WAIT;
          rd_code_d = src_eff;
        end else begin
          do_op = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (rd_fire) begin
          do_op = 1'b1;
`ifdef TIS_ANY_LAST_EN
          if (rd_code_q == C_ANY) last_d = rd_hit;
`endif
        end
      end
      S_WR_WAIT: begin
        if (wr_fire) begin
          pc_d    = pc_inc;
          state_d = S_EXEC;
`ifdef TIS_ANY_LAST_EN
          if (wr_code_q == C_ANY) last_d = wr_hit;
`endif
        end
      end
      default: ;  // HALTED: only reset leaves
    endcase

    if (do_op) begin
      state_d = S_EXEC;
      pc_d    = pc_inc;
      case (op)
        OP_NOP: ;
        OP_MOV: begin
          if (dst_chan) begin
            odata_d   = opv;
            wr_code_d = dst_eff;
            state_d   = S_WR_WAIT;
            pc_d      = pc_q;
          end else if (dst_eff == C_ACC) begin
            acc_d = opv;  // plain move, no saturation
          end
        end
        OP_SWP: begin
          acc_d = bak_q;
          bak_d = acc_q;
        end
        OP_SAV: bak_d = acc_q;
        OP_ADD: acc_d = sat({acc_q[W-1], acc_q} + {opv[W-1], opv});
        OP_SUB: acc_d = sat({acc_q[W-1], acc_q} - {opv[W-1], opv});
        OP_NEG: acc_d = sat((W+1)'(0) - {acc_q[W-1], acc_q});
        OP_JMP: pc_d = jmp_tgt;
        OP_JEZ: if (acc_q == '0) pc_d = jmp_tgt;
        OP_JNZ: if (acc_q != '0) pc_d = jmp_tgt;
        OP_JGZ: if (!acc_q[W-1] && (acc_q != '0)) pc_d = jmp_tgt;
        OP_JLZ: if (acc_q[W-1]) pc_d = jmp_tgt;
        OP_JRO: begin
          jro_t = $signed((W+2)'(pc_q)) + (W+2)'($signed(opv));
          if (jro_t < 0)              pc_d = '0;
          else if (jro_t > PC_LAST_S) pc_d = PC_LAST;
          else                        pc_d = jro_t[AW-1:0];
        end
        OP_HCF: begin
          state_d = S_HALTED;
          pc_d    = pc_q;
        end
        default: ;  // 14/15 are NOP
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: reset beats hlt, hlt freezes everything.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_EXEC;
      acc_q     <= '0;
      bak_q     <= '0;
      pc_q      <= '0;
      rd_code_q <= '0;
      wr_code_q <= '0;
      odata_q   <= '0;
`ifdef TIS_ANY_LAST_EN
      last_q    <= C_NIL;
`endif
    end else if (!hlt) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bak_q     <= bak_d;
      pc_q      <= pc_d;
      rd_code_q <= rd_code_d;
      wr_code_q <= wr_code_d;
      odata_q   <= odata_d;
`ifdef TIS_ANY_LAST_EN
      last_q    <= last_d;
`endif
    end
  end

  assign Addr_instr = pc_q;
  assign ACCond     = acc_q;
  assign busy       = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tis_exec_core.sv
// -----------------------------------------------------------------------------
// tb_tis_exec_core: directed bench for tis_exec_core (default build, W=8,
// NPORT=4, AW=8, PROG_LEN=16). The bench owns the instruction store and
// rewrites it between phases.
// -----------------------------------------------------------------------------
module tb_tis_exec_core;

  localparam int W        = 8;
  localparam int NPORT    = 4;
  localparam int AW       = 8;
  localparam int PROG_LEN = 16;
  localparam int IW       = 12 + W;

  localparam logic [3:0] NOP = 4'd0,  MOV = 4'd1,  SWP = 4'd2,  SAV = 4'd3;
  localparam logic [3:0] ADD = 4'd4,  SUB = 4'd5,  NEG = 4'd6,  JMP = 4'd7;
  localparam logic [3:0] JEZ = 4'd8,  JGZ = 4'd10, JLZ = 4'd11;
  localparam logic [3:0] JRO = 4'd12, HCF = 4'd13;
  localparam logic [3:0] IMM = 4'd0,  ACC = 4'd1;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 hlt;
  logic [IW-1:0]        instr;
  logic [AW-1:0]        Addr_instr;
  logic [NPORT*W-1:0]   in_data;
  logic [NPORT-1:0]     in_valid;
  logic [NPORT-1:0]     in_ready;
  logic [NPORT*W-1:0]   out_data;
  logic [NPORT-1:0]     out_valid;
  logic [NPORT-1:0]     out_ready;
  logic [W-1:0]         ACCond;
  logic                 busy;
  logic [1:0]           dbg_state;

  logic [IW-1:0] prog [PROG_LEN];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign instr = prog[Addr_instr[3:0]];

  tis_exec_core #(.W(W), .NPORT(NPORT), .AW(AW), .PROG_LEN(PROG_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .hlt        (hlt),
    .instr      (instr),
    .Addr_instr (Addr_instr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ACCond     (ACCond),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] s,
                                       input logic [3:0] d, input logic [7:0] im);
    return {op, s, d, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < PROG_LEN; i++) prog[i] = mk(NOP, IMM, IMM, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    hlt       = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = '0;

    // ---- Phase A: ALU saturation, port read/write, jumps, wrap -------------
    clear_prog();
    prog[0]  = mk(ADD, IMM, IMM, 8'd100);
    prog[1]  = mk(ADD, IMM, IMM, 8'd100);
    prog[2]  = mk(SUB, IMM, IMM, 8'd127);
    prog[3]  = mk(SUB, IMM, IMM, 8'd127);
    prog[4]  = mk(SUB, IMM, IMM, 8'd127);
    prog[5]  = mk(MOV, 4'd4, ACC, 8'h00);     // port1 -> ACC
    prog[6]  = mk(MOV, IMM, 4'd5, 8'd5);      // 5 -> port2
    prog[7]  = mk(SUB, IMM, IMM, 8'd42);
    prog[8]  = mk(JGZ, IMM, IMM, 8'd15);
    prog[9]  = mk(JEZ, IMM, IMM, 8'd11);
    prog[10] = mk(HCF, IMM, IMM, 8'h00);
    prog[11] = mk(ADD, IMM, IMM, 8'd3);
    prog[12] = mk(NEG, IMM, IMM, 8'h00);
    prog[13] = mk(JLZ, IMM, IMM, 8'd15);
    prog[14] = mk(HCF, IMM, IMM, 8'h00);
    do_reset();

    chk("rst_acc",       ACCond,    8'h00);
    chk("rst_pc",        Addr_instr, 8'h00);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_in_ready",  in_ready,  4'b0000);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out_data",  out_data,  32'h0);

    tick(); chk("add100_acc", ACCond, 8'd100); chk("add100_pc", Addr_instr, 8'd1);
    tick(); chk("add_sat_acc", ACCond, 8'd127);
    tick(); chk("sub_to_0", ACCond, 8'd0);
    tick(); chk("sub_neg127", ACCond, 8'h81);
    tick(); chk("sub_floor", ACCond, 8'h81); chk("sub_floor_pc", Addr_instr, 8'd5);

    // Port read, in_valid 3 cycles late.
    tick(); chk("rd_busy1", busy, 1'b1); chk("rd_ready1", in_ready, 4'b0010);
    chk("rd_pc_hold", Addr_instr, 8'd5);
    tick(); chk("rd_busy2", busy, 1'b1);
    tick(); chk("rd_busy3", busy, 1'b1); chk("rd_acc_hold", ACCond, 8'h81);
    in_valid = 4'b0010;
    in_data  = 32'h0000_2A00;
    #1; chk("rd_ready_pre", in_ready, 4'b0010);
    tick(); chk("rd_acc", ACCond, 8'h2A); chk("rd_pc", Addr_instr, 8'd6);
    chk("rd_busy_done", busy, 1'b0); chk("rd_ready_done", in_ready, 4'b0000);
    in_valid = '0;
    in_data  = '0;

    // Port write, out_ready held low 4 cycles.
    tick(); chk("wr_valid0", out_valid, 4'b0100); chk("wr_data", out_data, 32'h0505_0505);
    chk("wr_pc0", Addr_instr, 8'd6);
    for (int k = 1; k <= 3; k++) begin
      tick(); chk("wr_valid_stall", out_valid, 4'b0100); chk("wr_pc_stall", Addr_instr, 8'd6);
    end
    out_ready = 4'b0100;
    tick(); chk("wr_pc_adv", Addr_instr, 8'd7); chk("wr_valid_drop", out_valid, 4'b0000);
    chk("wr_acc_keep", ACCond, 8'h2A);
    out_ready = '0;

    tick(); chk("sub42_acc", ACCond, 8'd0); chk("sub42_pc", Addr_instr, 8'd8);
    tick(); chk("jgz_not_taken", Addr_instr, 8'd9);
    tick(); chk("jez_taken", Addr_instr, 8'd11);
    tick(); chk("add3_acc", ACCond, 8'd3);
    tick(); chk("neg_acc", ACCond, 8'hFD);
    tick(); chk("jlz_taken", Addr_instr, 8'd15);
    tick(); chk("pc_wrap", Addr_instr, 8'd0);

    // ---- Phase B: SWP, out-of-range port as NIL, JRO clamps -----------------
    clear_prog();
    prog[0]  = mk(ADD, IMM, IMM, 8'd7);
    prog[1]  = mk(SWP, IMM, IMM, 8'h00);
    prog[2]  = mk(ADD, 4'd7, IMM, 8'h00);     // port 4 >= NPORT -> reads 0
    prog[3]  = mk(JRO, IMM, IMM, 8'hEC);      // -20
    prog[15] = mk(NEG, IMM, IMM, 8'h00);
    do_reset();
    tick(); chk("b_add7", ACCond, 8'd7);
    tick(); chk("b_swp_acc", ACCond, 8'd0);
    tick(); chk("b_nil_port_pc", Addr_instr, 8'd3); chk("b_nil_port_busy", busy, 1'b0);
    tick(); chk("b_jro_neg_clamp", Addr_instr, 8'd0);
    prog[3] = mk(JRO, IMM, IMM, 8'd50);
    tick(); chk("b_add7_again", ACCond, 8'd7);
    tick(); chk("b_swp_bak", ACCond, 8'd7);
    tick(); chk("b_pc3", Addr_instr, 8'd3);
    tick(); chk("b_jro_pos_clamp", Addr_instr, 8'd15);
    tick(); chk("b_neg7", ACCond, 8'hF9); chk("b_wrap", Addr_instr, 8'd0);

    // ---- Phase C: MOV -128, NEG -128, hlt in RD_WAIT, reset in WR_WAIT ------
    clear_prog();
    prog[0] = mk(MOV, IMM, ACC, 8'h80);
    prog[1] = mk(NEG, IMM, IMM, 8'h00);
    prog[2] = mk(MOV, 4'd3, ACC, 8'h00);      // port0 -> ACC
    prog[3] = mk(MOV, IMM, 4'd6, 8'd9);       // 9 -> port3
    do_reset();
    tick(); chk("c_mov_m128", ACCond, 8'h80);
    tick(); chk("c_neg_m128", ACCond, 8'h7F);
    tick(); chk("c_rd_ready", in_ready, 4'b0001);
    hlt      = 1'b1;
    in_valid = 4'b0001;
    in_data  = 32'h0000_0011;
    #1; chk("c_hlt_ready_low", in_ready, 4'b0000);
    tick(); chk("c_hlt_acc", ACCond, 8'h7F); chk("c_hlt_pc", Addr_instr, 8'd2);
    tick(); chk("c_hlt_busy", busy, 1'b1);
    hlt = 1'b0;
    #1; chk("c_unhlt_ready", in_ready, 4'b0001);
    tick(); chk("c_capture_acc", ACCond, 8'h11); chk("c_capture_pc", Addr_instr, 8'd3);
    in_valid = '0;
    in_data  = '0;
    tick(); chk("c_wr_valid", out_valid, 4'b1000); chk("c_wr_data", out_data, 32'h0909_0909);
    hlt = 1'b1;
    #1; chk("c_hlt_out_valid", out_valid, 4'b0000);
    hlt       = 1'b0;
    out_ready = 4'b1000;
    reset     = 1'b1;
    tick();
    chk("c_rst_pc", Addr_instr, 8'd0);  chk("c_rst_acc", ACCond, 8'd0);
    chk("c_rst_out_valid", out_valid, 4'b0000); chk("c_rst_out_data", out_data, 32'h0);
    chk("c_rst_busy", busy, 1'b0);      chk("c_rst_in_ready", in_ready, 4'b0000);
    reset     = 1'b0;
    out_ready = '0;

    // ---- Phase D: JMP modulo PROG_LEN, HCF -----------------------------------
    clear_prog();
    prog[0] = mk(JMP, IMM, IMM, 8'd35);
    prog[3] = mk(HCF, IMM, IMM, 8'h00);
    prog[4] = mk(ADD, IMM, IMM, 8'd1);
    do_reset();
    tick(); chk("d_jmp_mod", Addr_instr, 8'd3);
    tick(); chk("d_hcf_state", dbg_state, 2'd3);
    tick(); tick();
    chk("d_halt_pc", Addr_instr, 8'd3); chk("d_halt_acc", ACCond, 8'd0);
    chk("d_halt_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tis_exec_core.md
Name: tis_exec_core

Overview:
Parametrised successor of the TIS node execution path. Merges ACC/BAK datapath, saturating ALU, PC/jump logic and blocking valid/ready neighbour ports into one core. Width, port count and program length are generic. Instruction store sits outside the core, read asynchronously by PC. Sits inside each TIS node and connects to neighbour nodes through the port handshake.

Parameters:
W, 8, data/ACC/BAK width, signed two's complement
NPORT, 4, neighbour port count, 1..8
AW, 8, PC width; AW <= W
PROG_LEN, 16, instruction count; PC wraps at PROG_LEN; 2 <= PROG_LEN <= 2^AW

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
hlt  in  1  freeze: no state change while high
instr  in  12+W  instruction at Addr_instr: op[IW-1:IW-4], src[-4], dst[-4], imm[W-1:0]
Addr_instr  out  AW  program counter
in_data  in  NPORT*W  port i data in slice [i*W +: W]
in_valid  in  NPORT  neighbour offers data
in_ready  out  NPORT  core accepting on port i
out_data  out  NPORT*W  write data; the same value is driven on all slices
out_valid  out  NPORT  core offering data on port i
out_ready  in  NPORT  neighbour accepts
ACCond  out  W  current ACC
busy  out  1  high in RD_WAIT or WR_WAIT

Behaviour:
- Reset: ACC=0, BAK=0, PC=0, state=EXEC, in_ready=0, out_valid=0, out_data=0, busy=0.
- Operand codes (src/dst): 0 IMM (src only), 1 ACC, 2 NIL (read 0, write discards), 3+i port i for i<NPORT; 14/15 per optional feature; others read 0 / discard.
- Opcodes: 0 NOP, 1 MOV src->dst, 2 SWP, 3 SAV (BAK=ACC), 4 ADD src, 5 SUB src, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ, 12 JRO src, 13 HCF (halt forever until reset), 14/15 NOP.
- Jumps 7-11: target=imm[AW-1:0] mod PROG_LEN. Condition is tested on ACC before the instruction executes. If the condition is false, PC advances.
- JRO: PC = clamp(PC+signed src, 0, PROG_LEN-1).
- PC advance: PC+1, wraps PROG_LEN-1 -> 0.
- Arithmetic: compute in W+1 bits, then saturate to [-(2^(W-1)-1), +(2^(W-1)-1)]. W=8 gives ±127. NEG of -128 gives +127. MOV imm -128 to ACC stores -128 unsaturated.
- FSM states: EXEC, RD_WAIT, WR_WAIT, HALTED.
  - EXEC, src not a port: execute in 1 cycle. ACC/BAK/PC update on the next edge.
  - EXEC, src port p: go to RD_WAIT. The PC holds.
  - RD_WAIT: in_ready[p]=1, all other bits 0. On the cycle where in_valid[p]&in_ready[p] is high, the datum is latched and the op completes at that edge. If dst is not a port, ACC/PC update at the same edge and the FSM returns to EXEC. If dst is a port, go to WR_WAIT.
  - EXEC, MOV to port q with a non-port src: out_data=value and go to WR_WAIT.
  - WR_WAIT: out_valid[q]=1. On out_valid[q]&out_ready[q], PC advances and the FSM returns to EXEC.
  - Port->port MOV takes at least 2 handshakes, read first then write.
  - HCF: go to HALTED. Only reset leaves HALTED.
- Port index >= NPORT is treated as NIL: no stall.
- hlt high: all registers and the FSM hold. in_ready/out_valid are forced to 0, so no transfer can occur. Latched read data is kept.
- Reset has priority over hlt and over any pending handshake. A transfer that completes in the reset cycle is lost.
- Latency: non-port instruction 1 cycle. Port read 1 cycle after in_valid if it is already high on entering RD_WAIT: cycle 1 EXEC, cycle 2 RD_WAIT handshake.

Optional Feature:
Macro TIS_ANY_LAST_EN.
- Defined:
  - src/dst 15 = ANY. On read, the lowest-index port with in_valid wins; in_ready is raised on all ports and granted to that port only. On write, out_valid is raised on all ports; the first out_ready (lowest index) completes and all out_valid drop.
  - src/dst 14 = LAST, the port most recently used by ANY. Reset value is NIL.
- Undefined: codes 14/15 behave as NIL.

Test Plan:
- Reset, then ADD imm 100 twice with W=8 -> ACC=100 then 127 (saturated); SUB imm 127 x3 -> -127 floor.
- MOV port1->ACC, in_valid[1] raised 3 cycles late with 0x2A -> busy high 3 cycles, in_ready=0010, ACC=42, PC+1 after handshake.
- MOV imm 5 -> port2, out_ready held low 4 cycles -> out_valid=0100 stable, out_data=5, PC frozen; advances the cycle after out_ready.
- JEZ/JGZ with ACC=0, JRO -20 at PC=3 and JRO +50 at PC=3 -> jump taken/not, PC=0 and PC=PROG_LEN-1; PC wraps 15->0.
- hlt asserted mid-RD_WAIT with in_valid high -> in_ready=0, no capture; deassert -> capture. Reset during WR_WAIT -> all outputs at reset values next cycle.
- (TIS_ANY_LAST_EN) MOV ANY->ACC with in_valid=1010 -> port1 data taken, LAST=1; MOV ACC->LAST drives out_valid=0010.
